prog_mem_loader: RTL and testbench

- Streaming loader that fills the instruction BRAM and the data BRAM before execution, and holds the core stalled until released.
- Sits between a word-stream source (host/UART bridge/testbench) and the write ports of both bram32 instances; drives the pc stall input.
- Parametrised in data width, address width and number of memory channels.
- Replaces ad-hoc testbench preload loops with synthesizable hardware.

---
 rtl/prog_mem_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_prog_mem_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: streams words from a host source into one of N_CH BRAM
// write ports (ch0 = instruction, ch1 = data) and holds the core stalled
// until it is explicitly released with run.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, adds ld_csum_exp / ld_csum and a running-sum integrity
//   check that flags ld_err at completion on mismatch.

module prog_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int N_CH       = 2,
    parameter int MAX_WORDS  = (2**ADDR_WIDTH) / (DATA_WIDTH/8)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_start,
    input  logic [$clog2(N_CH)-1:0]      ld_ch,
    input  logic [ADDR_WIDTH:0]          ld_count,
    input  logic [ADDR_WIDTH-1:0]        ld_base,
    input  logic                         run,
    input  logic                         s_valid,
    input  logic [DATA_WIDTH-1:0]        s_data,
    output logic                         s_ready,
    output logic [N_CH*ADDR_WIDTH-1:0]   w_addr,
    output logic [N_CH*DATA_WIDTH-1:0]   w_dat,
    output logic [N_CH-1:0]              w_enb,
    output logic                         cpu_stall,
    output logic                         ld_busy,
    output logic                         ld_done,
`ifdef LOADER_CHECKSUM_EN
    input  logic [DATA_WIDTH-1:0]        ld_csum_exp,
    output logic [DATA_WIDTH-1:0]        ld_csum,
`endif
    output logic                         ld_err
);

    localparam int CH_W      = $clog2(N_CH);
    localparam int STRIDE    = DATA_WIDTH / 8;
    localparam int STRIDE_LG = $clog2(STRIDE);

    // Low address bits that must be zero for a word-aligned base.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRIDE - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A   = ADDR_WIDTH'(STRIDE);
    // Two extra bits so base-word-index + count never overflows the compare.
    localparam logic [ADDR_WIDTH+1:0] MAX_W      = (ADDR_WIDTH+2)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH:0]   ONE_CNT    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   ZERO_CNT   = (ADDR_WIDTH+1)'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                              r_state;
    state_t                              w_next;

    logic [CH_W-1:0]                     r_ch;
    logic [ADDR_WIDTH-1:0]               r_addr;
    logic [ADDR_WIDTH:0]                 r_remain;
    logic                                r_s_ready;
    logic                                r_busy;
    logic                                r_done;
    logic                                r_err;
    logic                                r_stall;
    logic [N_CH-1:0]                     r_w_enb;
    logic [N_CH-1:0][ADDR_WIDTH-1:0]     r_w_addr;
    logic [N_CH-1:0][DATA_WIDTH-1:0]     r_w_dat;

    logic                                w_accept;
    logic                                w_hs;
    logic                                w_range_bad;
    logic                                w_start_bad;
    logic [ADDR_WIDTH+1:0]               w_word_end;
    logic                                w_csum_bad;

    assign w_accept   = (r_state == ST_IDLE) && ld_start;
    assign w_hs       = (r_state == ST_LOAD) && r_s_ready && s_valid;
    // Last word index (exclusive) the requested load would touch.
    assign w_word_end = {2'b00, (ld_base >> STRIDE_LG)} + {1'b0, ld_count};

    // Request validation: capacity, alignment and end-of-memory bound.
    always_comb begin
        w_range_bad = 1'b0;
        if (({1'b0, ld_count} > MAX_W) ||
            ((ld_base & ALIGN_MASK) != {ADDR_WIDTH{1'b0}}) ||
            (w_word_end > MAX_W)) begin
            w_range_bad = 1'b1;
        end else begin
            w_range_bad = 1'b0;
        end
    end

    // Next-state logic; a zero-length request completes without streaming.
    always_comb begin
        w_next      = r_state;
        w_start_bad = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ld_start) begin
                    if (ld_count == ZERO_CNT) begin
                        w_next = ST_FINISH;
                    end else if (w_range_bad) begin
                        w_start_bad = 1'b1;
                        w_next      = ST_IDLE;
                    end else begin
                        w_next = ST_LOAD;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_hs && (r_remain == ONE_CNT)) begin
                    w_next = ST_FINISH;
                end else begin
                    w_next = ST_LOAD;
                end
            end
            ST_FINISH: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;
    logic [DATA_WIDTH-1:0] r_csum_exp;
    logic [DATA_WIDTH-1:0] w_csum_sum;

    assign w_csum_sum = r_csum + s_data;
    assign ld_csum    = r_csum;

    // Final-sum compare, evaluated on the transition into FINISH so the
    // error flag lands in the same cycle as ld_done.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_csum_bad = (ld_csum_exp != {DATA_WIDTH{1'b0}});
        end else begin
            w_csum_bad = (w_csum_sum != r_csum_exp);
        end
    end

    // Running checksum of accepted words, restarted by each accepted load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum     <= {DATA_WIDTH{1'b0}};
            r_csum_exp <= {DATA_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_csum     <= {DATA_WIDTH{1'b0}};
            r_csum_exp <= ld_csum_exp;
        end else if (w_hs) begin
            r_csum     <= w_csum_sum;
        end
    end
`else
    assign w_csum_bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered status outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_s_ready <= (w_next == ST_LOAD);
            r_busy    <= (w_next == ST_LOAD);
            r_done    <= (w_next == ST_FINISH);
        end
    end

    // Request latch, error flag and core stall control; ld_start beats run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch     <= {CH_W{1'b0}};
            r_err    <= 1'b0;
            r_stall  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_ch    <= ld_ch;
                r_err   <= w_start_bad;
                r_stall <= 1'b1;
            end else if ((r_state == ST_IDLE) && run && !r_err) begin
                r_stall <= 1'b0;
            end
            if ((w_next == ST_FINISH) && w_csum_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // Address/count bookkeeping and the one-cycle BRAM write per handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= {ADDR_WIDTH{1'b0}};
            r_remain <= ZERO_CNT;
            r_w_enb  <= {N_CH{1'b0}};
            r_w_addr <= '0;
            r_w_dat  <= '0;
        end else begin
            r_w_enb <= {N_CH{1'b0}};
            if (w_accept) begin
                r_addr   <= ld_base;
                r_remain <= ld_count;
            end else if (w_hs) begin
                r_w_enb[r_ch]  <= 1'b1;
                r_w_addr[r_ch] <= r_addr;
                r_w_dat[r_ch]  <= s_data;
                r_addr         <= r_addr + STRIDE_A;
                r_remain       <= r_remain - ONE_CNT;
            end
        end
    end

    assign s_ready   = r_s_ready;
    assign w_addr    = r_w_addr;
    assign w_dat     = r_w_dat;
    assign w_enb     = r_w_enb;
    assign cpu_stall = r_stall;
    assign ld_busy   = r_busy;
    assign ld_done   = r_done;
    assign ld_err    = r_err;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader (default parameters).
// Expected BRAM writes are queued when words are offered and popped by a
// write monitor; status outputs are checked inline by each scenario task.
// Define LOADER_CHECKSUM_EN to also exercise the checksum scenario.

module tb_prog_mem_loader;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int MAXW = 256;

    typedef struct packed {
        logic          ch;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ld_start = 1'b0;
    logic            ld_ch = 1'b0;
    logic [AW:0]     ld_count = '0;
    logic [AW-1:0]   ld_base = '0;
    logic            run = 1'b0;
    logic            s_valid = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_ready;
    logic [2*AW-1:0] w_addr;
    logic [2*DW-1:0] w_dat;
    logic [1:0]      w_enb;
    logic            cpu_stall;
    logic            ld_busy;
    logic            ld_done;
    logic            ld_err;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0]   ld_csum_exp = '0;
    logic [DW-1:0]   ld_csum;
`endif

    int  total = 0;
    int  bad   = 0;
    wr_t sb[$];
    wr_t mon_e;

    prog_mem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .ld_start  (ld_start),
        .ld_ch     (ld_ch),
        .ld_count  (ld_count),
        .ld_base   (ld_base),
        .run       (run),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .w_addr    (w_addr),
        .w_dat     (w_dat),
        .w_enb     (w_enb),
        .cpu_stall (cpu_stall),
        .ld_busy   (ld_busy),
        .ld_done   (ld_done),
`ifdef LOADER_CHECKSUM_EN
        .ld_csum_exp (ld_csum_exp),
        .ld_csum     (ld_csum),
`endif
        .ld_err    (ld_err)
    );

    always #5 clk = ~clk;

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Write monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                if (w_enb[c]) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_write ch=%0d addr=%h dat=%h", c, w_addr[c*AW +: AW], w_dat[c*DW +: DW]);
                    end else begin
                        mon_e = sb.pop_front();
                        if ((mon_e.ch !== 1'(c)) || (w_addr[c*AW +: AW] !== mon_e.addr) || (w_dat[c*DW +: DW] !== mon_e.dat)) begin
                            bad++;
                            $display("FAIL write got ch=%0d addr=%h dat=%h want ch=%0d addr=%h dat=%h",
                                     c, w_addr[c*AW +: AW], w_dat[c*DW +: DW], mon_e.ch, mon_e.addr, mon_e.dat);
                        end
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse ld_start (optionally with run in the same cycle).
    task automatic start_load(input logic ch, input logic [AW-1:0] base, input logic [AW:0] cnt, input bit with_run);
        ld_ch    = ch;
        ld_base  = base;
        ld_count = cnt;
        ld_start = 1'b1;
        run      = with_run;
        tick();
        ld_start = 1'b0;
        run      = 1'b0;
    endtask

    task automatic pulse_run;
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // Offer each word until accepted; returns one cycle after the last handshake.
    task automatic stream_words(input logic [DW-1:0] words[$], input logic ch, input logic [AW-1:0] base, input bit gap);
        int  budget;
        bit  hs;
        for (int i = 0; i < words.size(); i++) begin
            if (gap && (i > 0)) begin
                s_valid = 1'b0;
                tick();
            end
            sb.push_back('{ch: ch, addr: base + AW'(4*i), dat: words[i]});
            s_valid = 1'b1;
            s_data  = words[i];
            budget  = 20;
            hs      = 1'b0;
            while (!hs && (budget > 0)) begin
                hs = s_ready;
                tick();
                budget--;
            end
            if (!hs) begin
                total++;
                bad++;
                $display("FAIL handshake_timeout word=%0d", i);
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) tick();
        total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
        total++; if (w_enb !== 2'b00)    begin bad++; $display("FAIL rst_w_enb got=%b want=00", w_enb); end
        total++; if (w_addr !== '0)      begin bad++; $display("FAIL rst_w_addr got=%h want=0", w_addr); end
        total++; if (w_dat !== '0)       begin bad++; $display("FAIL rst_w_dat got=%h want=0", w_dat); end
        total++; if ({cpu_stall, ld_busy, ld_done, ld_err} !== 4'b1000) begin
            bad++; $display("FAIL rst_status got=%b want=1000", {cpu_stall, ld_busy, ld_done, ld_err});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load7_ch0;
        logic [DW-1:0] w[$];
        for (int i = 0; i < 7; i++) w.push_back($urandom());
        start_load(1'b0, 10'h000, 11'd7, 1'b0);
        total++; if (ld_busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b want=1", ld_busy); end
        stream_words(w, 1'b0, 10'h000, 1'b0);
        total++; if (ld_done !== 1'b1)   begin bad++; $display("FAIL t1_done got=%b want=1", ld_done); end
        total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL t1_ready_drop got=%b want=0", s_ready); end
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL t1_stall got=%b want=1", cpu_stall); end
        tick();
        total++; if ({ld_done, ld_busy} !== 2'b00) begin bad++; $display("FAIL t1_idle got=%b want=00", {ld_done, ld_busy}); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL t1_drain got=%0d want=0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_gapped_ch1_run(input logic [DW-1:0] ch0_last);
        logic [DW-1:0] w[$];
        w = '{32'd1, 32'd3, 32'd5};
        start_load(1'b1, 10'h004, 11'd3, 1'b0);
        stream_words(w, 1'b1, 10'h004, 1'b1);
        total++; if (ld_done !== 1'b1) begin bad++; $display("FAIL t2_done got=%b want=1", ld_done); end
        total++; if (w_addr[AW-1:0] !== 10'h018) begin bad++; $display("FAIL t2_ch0_addr_hold got=%h want=018", w_addr[AW-1:0]); end
        total++; if (w_dat[DW-1:0] !== ch0_last) begin bad++; $display("FAIL t2_ch0_dat_hold got=%h want=%h", w_dat[DW-1:0], ch0_last); end
        tick();
        pulse_run();
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL t2_run_release got=%b want=0", cpu_stall); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL t2_drain got=%0d want=0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_errors;
        logic [DW-1:0] w[$];
        logic [AW-1:0] bases[3] = '{10'h000, 10'h002, 10'h3FC};
        logic [AW:0]   cnts[3]  = '{11'(MAXW + 1), 11'd1, 11'd2};
        for (int k = 0; k < 3; k++) begin
            start_load(1'b0, bases[k], cnts[k], 1'b0);
            total++; if (ld_err !== 1'b1)  begin bad++; $display("FAIL t3_err_%0d got=%b want=1", k, ld_err); end
            total++; if ({ld_busy, s_ready} !== 2'b00) begin bad++; $display("FAIL t3_idle_%0d got=%b want=00", k, {ld_busy, s_ready}); end
            total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL t3_stall_%0d got=%b want=1", k, cpu_stall); end
            s_valid = 1'b1;
            s_data  = 32'hDEAD_BEEF;
            repeat (3) tick();
            s_valid = 1'b0;
            pulse_run();
            total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL t3_run_blocked_%0d got=%b want=1", k, cpu_stall); end
        end
        // Last word of the memory is a legal single-word load and clears the error.
        w = '{32'hCAFE_0001};
        start_load(1'b1, 10'h3FC, 11'd1, 1'b0);
        total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL t3_err_clear got=%b want=0", ld_err); end
        stream_words(w, 1'b1, 10'h3FC, 1'b0);
        total++; if (ld_done !== 1'b1) begin bad++; $display("FAIL t3_top_done got=%b want=1", ld_done); end
        tick();
        pulse_run();
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL t3_top_run got=%b want=0", cpu_stall); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL t3_drain got=%0d want=0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_zero_count;
        start_load(1'b0, 10'h000, 11'd0, 1'b1);
        total++; if (ld_done !== 1'b1)   begin bad++; $display("FAIL t4_done got=%b want=1", ld_done); end
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL t4_stall got=%b want=1", cpu_stall); end
        total++; if ({ld_busy, ld_err} !== 2'b00) begin bad++; $display("FAIL t4_flags got=%b want=00", {ld_busy, ld_err}); end
        tick();
        total++; if (ld_done !== 1'b0) begin bad++; $display("FAIL t4_done_pulse got=%b want=0", ld_done); end
        tick();
    endtask

    task automatic test_reset_mid_load;
        logic [DW-1:0] w[$];
        logic [DW-1:0] w2[$];
        for (int i = 0; i < 5; i++) w.push_back($urandom());
        w2 = '{w[0], w[1]};
        start_load(1'b0, 10'h020, 11'd5, 1'b0);
        stream_words(w2, 1'b0, 10'h020, 1'b0);
        #6;
        rst = 1'b1;
        #1;
        total++; if ({s_ready, w_enb} !== 3'b000) begin bad++; $display("FAIL t5_rst_io got=%b want=000", {s_ready, w_enb}); end
        total++; if ((w_addr !== '0) || (w_dat !== '0)) begin bad++; $display("FAIL t5_rst_bus got=%h/%h want=0", w_addr, w_dat); end
        total++; if ({cpu_stall, ld_busy, ld_done, ld_err} !== 4'b1000) begin
            bad++; $display("FAIL t5_rst_status got=%b want=1000", {cpu_stall, ld_busy, ld_done, ld_err});
        end
        #2;
        rst = 1'b0;
        sb.delete();
        tick();
        start_load(1'b0, 10'h020, 11'd5, 1'b0);
        stream_words(w, 1'b0, 10'h020, 1'b0);
        total++; if (ld_done !== 1'b1) begin bad++; $display("FAIL t5_restart_done got=%b want=1", ld_done); end
        tick();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL t5_drain got=%0d want=0", sb.size()); end
        sb.delete();
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        logic [DW-1:0] w[$];
        logic [DW-1:0] exps[2] = '{32'd9, 32'd8};
        for (int k = 0; k < 2; k++) begin
            w = '{32'd1, 32'd3, 32'd5};
            ld_csum_exp = exps[k];
            start_load(1'b1, 10'h010, 11'd3, 1'b0);
            stream_words(w, 1'b1, 10'h010, 1'b0);
            total++; if (ld_done !== 1'b1) begin bad++; $display("FAIL t6_done_%0d got=%b want=1", k, ld_done); end
            total++; if (ld_err !== 1'(k)) begin bad++; $display("FAIL t6_err_%0d got=%b want=%0d", k, ld_err, k); end
            total++; if (ld_csum !== 32'd9) begin bad++; $display("FAIL t6_csum_%0d got=%0d want=9", k, ld_csum); end
            tick();
            pulse_run();
            total++; if (cpu_stall !== 1'(k)) begin bad++; $display("FAIL t6_run_%0d got=%b want=%0d", k, cpu_stall, k); end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL t6_drain got=%0d want=0", sb.size()); end
        sb.delete();
    endtask
`endif

    initial begin
        logic [DW-1:0] ch0_last;
        test_reset();
        test_load7_ch0();
        ch0_last = w_dat[DW-1:0];
        // ch0_last is re-derived from the t1 stream via the monitor-checked write
        test_gapped_ch1_run(ch0_last);
        test_errors();
        test_zero_count();
        test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
